// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the MEM-stage data-memory responder: FSM state
// encoding, word-alignment width and the upper bound on wait states.
// ----------------------------------------------------------------------------
package mem_resp_pkg;

    localparam int WORD_ALIGN_BITS = 2;
    localparam int MAX_WAIT_STATES = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
// MEM-stage data-memory request/response bundle.
//   master : pipeline side, drives mem_read_i/mem_write_i/address_i/write_data_i
//   slave  : responder side, drives data_o/stall_o/done_o/misaligned_o
// ----------------------------------------------------------------------------
interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_read_i;
    logic                  mem_write_i;
    logic [31:0]           address_i;
    logic [DATA_WIDTH-1:0] write_data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  stall_o;
    logic                  done_o;
    logic                  misaligned_o;

    modport master (
        output mem_read_i, mem_write_i, address_i, write_data_i,
        input  data_o, stall_o, done_o, misaligned_o
    );

    modport slave (
        input  mem_read_i, mem_write_i, address_i, write_data_i,
        output data_o, stall_o, done_o, misaligned_o
    );
endinterface

// File: rtl/data_mem_responder_sp_ram.sv
// ----------------------------------------------------------------------------
// sp_ram
// Synchronous single-port RAM, DATA_WIDTH x DEPTH, read-first registered
// output. The output register only loads on i_re, so it holds the last
// read word across writes and idle cycles.
//   clk, reset : clock, synchronous active-high reset (output register only)
//   i_we       : write i_wdata to i_addr
//   i_re       : load o_rdata from i_addr (old contents if written same edge)
//   o_rdata    : registered read data
// ----------------------------------------------------------------------------
module sp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // NOTE: the array has no reset branch; clearing it would force it out of
    // RAM macros into flops, and its contents are meant to survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // NOTE: non-blocking assignment samples r_mem before this edge's write,
    // which is exactly what gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Responder for the pipeline's MEM-stage data access. Accepts a read/write
// request, waits WAIT_STATES cycles, performs the RAM access on the edge
// entering RESP, and stalls the pipeline until then.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : slave modport (mem_read_i, mem_write_i, address_i, write_data_i
//            in; data_o, stall_o, done_o, misaligned_o out)
// ----------------------------------------------------------------------------
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 256,
    parameter int WAIT_STATES  = 2
) (
    input  logic                clk,
    input  logic                reset,
    data_mem_responder_if.slave bus
);

    localparam int ADDR_WIDTH = $clog2(MEMORY_DEPTH);
    localparam int CNT_WIDTH  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(WAIT_STATES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_misaligned;
    logic                  w_req;
    logic                  w_misaligned;
    logic                  w_fire;
    logic                  w_we;
    logic                  w_re;
    logic [ADDR_WIDTH-1:0] w_index;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_addr;

    assign w_req        = bus.mem_read_i | bus.mem_write_i;
    assign w_misaligned = |bus.address_i[WORD_ALIGN_BITS-1:0];
    assign w_index      = bus.address_i[ADDR_WIDTH+WORD_ALIGN_BITS-1:WORD_ALIGN_BITS];

    // Upper byte-address bits alias onto the same words.
    assign w_unused_addr = ^bus.address_i[31:ADDR_WIDTH+WORD_ALIGN_BITS];

    // w_fire marks the edge entering RESP with a real RAM access.
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_fire       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_misaligned) begin
                        w_next_state = S_RESP;
                    end else if (WAIT_STATES == 0) begin
                        w_next_state = S_RESP;
                        w_fire       = 1'b1;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_count == CNT_ONE) begin
                    w_next_state = S_RESP;
                    w_fire       = 1'b1;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            // Only set for the one RESP cycle that follows a misaligned request.
            r_misaligned <= (r_state == S_IDLE) && w_req && w_misaligned;
            if (r_state == S_IDLE && w_req && !w_misaligned) begin
                r_count <= CNT_LOAD;
            end else if (r_state == S_WAIT) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // A simultaneous read+write performs only the write, so data_o holds.
    // Reset gating makes a reset in WAIT abort the access cleanly.
    assign w_we = w_fire & bus.mem_write_i & ~reset;
    assign w_re = w_fire & bus.mem_read_i & ~bus.mem_write_i & ~reset;

    sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEMORY_DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_index),
        .i_wdata (bus.write_data_i),
        .o_rdata (w_rdata)
    );

    assign bus.data_o       = w_rdata;
    assign bus.stall_o      = ~reset & (((r_state == S_IDLE) & w_req) | (r_state == S_WAIT));
    assign bus.done_o       = ~reset & (r_state == S_RESP);
    assign bus.misaligned_o = bus.done_o & r_misaligned;

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder with two instances: WAIT_STATES = 2
// and WAIT_STATES = 0. Inputs change on the falling edge; outputs are sampled
// on the falling edge, away from the active rising edge.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2;
    logic rst0;

    data_mem_responder_if #(.DATA_WIDTH(32)) b2 ();
    data_mem_responder_if #(.DATA_WIDTH(32)) b0 ();

    data_mem_responder #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (256),
        .WAIT_STATES  (2)
    ) dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (b2.slave)
    );

    data_mem_responder #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (256),
        .WAIT_STATES  (0)
    ) dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (b0.slave)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // sel0 = 1 selects the WAIT_STATES = 0 instance.
    function automatic logic [31:0] o_stall(input bit sel0);
        return {31'd0, sel0 ? b0.stall_o : b2.stall_o};
    endfunction

    function automatic logic [31:0] o_done(input bit sel0);
        return {31'd0, sel0 ? b0.done_o : b2.done_o};
    endfunction

    function automatic logic [31:0] o_mis(input bit sel0);
        return {31'd0, sel0 ? b0.misaligned_o : b2.misaligned_o};
    endfunction

    function automatic logic [31:0] o_data(input bit sel0);
        return sel0 ? b0.data_o : b2.data_o;
    endfunction

    task automatic drive(input bit sel0, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel0) begin
            b0.mem_read_i   = rd;
            b0.mem_write_i  = wr;
            b0.address_i    = addr;
            b0.write_data_i = wdata;
        end else begin
            b2.mem_read_i   = rd;
            b2.mem_write_i  = wr;
            b2.address_i    = addr;
            b2.write_data_i = wdata;
        end
    endtask

    // One complete access: request held until the done cycle, then dropped.
    // Aligned: stall for WS+1 cycles, done on the next. Misaligned: done next cycle.
    task automatic access(input bit sel0, input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_mis, input logic [31:0] exp_data);
        int ws  = sel0 ? 0 : 2;
        int lat = exp_mis ? 1 : ws + 1;
        @(negedge clk);
        drive(sel0, rd, wr, addr, wdata);
        #1;
        check({tag, " stall_req"}, o_stall(sel0), 32'd1);
        check({tag, " done_req"}, o_done(sel0), 32'd0);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check({tag, " stall_wait"}, o_stall(sel0), 32'd1);
            check({tag, " done_wait"}, o_done(sel0), 32'd0);
        end
        @(negedge clk);
        check({tag, " done"}, o_done(sel0), 32'd1);
        check({tag, " stall_resp"}, o_stall(sel0), 32'd0);
        check({tag, " misaligned"}, o_mis(sel0), {31'd0, exp_mis});
        check({tag, " data"}, o_data(sel0), exp_data);
        drive(sel0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check({tag, " stall_idle"}, o_stall(sel0), 32'd0);
        @(negedge clk);
        check({tag, " done_idle"}, o_done(sel0), 32'd0);
        check({tag, " mis_idle"}, o_mis(sel0), 32'd0);
    endtask

    // Requester protocol: inputs must not change between consecutive stalled cycles.
    logic        p_stall = 1'b0;
    logic [65:0] p_in    = '0;
    always @(posedge clk) begin
        if (b2.stall_o === 1'b1 && p_stall === 1'b1) begin
            assert ({b2.mem_read_i, b2.mem_write_i, b2.address_i, b2.write_data_i} === p_in)
            else $error("FAIL protocol: inputs changed while stalled");
        end
        p_stall <= b2.stall_o;
        p_in    <= {b2.mem_read_i, b2.mem_write_i, b2.address_i, b2.write_data_i};
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst2 = 1'b1;
        rst0 = 1'b1;

        // Reset with a read request pending: stall must stay low.
        b2.mem_read_i = 1'b1;
        b2.address_i  = 32'h10;
        #1;
        check("rst stall_comb", o_stall(1'b0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst stall", o_stall(1'b0), 32'd0);
            check("rst done", o_done(1'b0), 32'd0);
        end
        check("rst data", o_data(1'b0), 32'h0);

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst2 = 1'b0;
        rst0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle stall", o_stall(1'b0), 32'd0);
            check("idle done", o_done(1'b0), 32'd0);
            check("idle mis", o_mis(1'b0), 32'd0);
            check("idle data", o_data(1'b0), 32'h0);
        end

        // WAIT_STATES = 2
        access(1'b0, "ws2 wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        access(1'b0, "ws2 rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        access(1'b0, "ws2 mis12", 1'b1, 1'b0, 32'h12, 32'h0, 1'b1, 32'hDEADBEEF);
        access(1'b0, "ws2 rw20", 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'hDEADBEEF);
        access(1'b0, "ws2 rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678);
        access(1'b0, "ws2 wr08", 1'b0, 1'b1, 32'h8, 32'h11112222, 1'b0, 32'h12345678);

        // Write aborted by reset in the second WAIT cycle.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h8, 32'hCAFE0000);
        #1;
        check("abort stall_req", o_stall(1'b0), 32'd1);
        @(negedge clk);
        check("abort stall_wait1", o_stall(1'b0), 32'd1);
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        check("abort stall_in_reset", o_stall(1'b0), 32'd0);
        @(negedge clk);
        check("abort done_reset", o_done(1'b0), 32'd0);
        check("abort data_reset", o_data(1'b0), 32'h0);
        rst2 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("abort stall_after", o_stall(1'b0), 32'd0);
        @(negedge clk);
        check("abort done_after", o_done(1'b0), 32'd0);
        access(1'b0, "ws2 rd08", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h11112222);

        // WAIT_STATES = 0, including the top word and an aliased address.
        access(1'b1, "ws0 wr000", 1'b0, 1'b1, 32'h0, 32'hA0A0A0A0, 1'b0, 32'h0);
        access(1'b1, "ws0 rd000", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'hA0A0A0A0);
        access(1'b1, "ws0 wr004", 1'b0, 1'b1, 32'h4, 32'hB1B1B1B1, 1'b0, 32'hA0A0A0A0);
        access(1'b1, "ws0 rd004", 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'hB1B1B1B1);
        access(1'b1, "ws0 wr3fc", 1'b0, 1'b1, 32'h3FC, 32'hC2C2C2C2, 1'b0, 32'hB1B1B1B1);
        access(1'b1, "ws0 rd3fc", 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hC2C2C2C2);
        access(1'b1, "ws0 rd400", 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 32'hA0A0A0A0);
        access(1'b1, "ws0 mis003", 1'b1, 1'b0, 32'h3, 32'h0, 1'b1, 32'hA0A0A0A0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder side of the MEM-stage data-memory interface: accepts the pipeline's mem_read/mem_write request, serves it from an internal word-addressed RAM after a programmable number of wait states, and holds the pipeline with a stall signal until the access completes. It sits between the EX/MEM pipeline register outputs (control, ALU result as address, forwarded rt data) and the write-back mux. It replaces the zero-latency memory model so that slow memories can be modelled without changing pipeline RTL.

## Interface
- DATA_WIDTH, 32, word width in bits
- MEMORY_DEPTH, 256, number of words; power of two, ≥ 4
- WAIT_STATES, 2, extra cycles per access; 0..15
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- mem_read_i  input  1  read request
- mem_write_i  input  1  write request
- address_i  input  32  byte address (ALU result)
- write_data_i  input  DATA_WIDTH  store data
- data_o  output  DATA_WIDTH  read data, registered
- stall_o  output  1  pipeline must hold IF/ID/EX/MEM registers
- done_o  output  1  one-cycle pulse, access complete
- misaligned_o  output  1  one-cycle pulse, request had address_i[1:0] ≠ 0

## Operation
- Word index = address_i[$clog2(MEMORY_DEPTH)+1:2]; upper address bits ignored (aliasing wraps).
- Request present = mem_read_i | mem_write_i. Both asserted: write performed, data_o unchanged.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: request present and aligned → WAIT (counter loaded with WAIT_STATES), or directly RESP if WAIT_STATES = 0. Misaligned request → RESP without RAM access, misaligned_o pulses with done_o.
  - WAIT: counter decrements each cycle; at 1 → RESP.
  - RESP: done_o = 1, stall_o = 0; unconditionally → IDLE (the request seen this cycle is the same one; never re-accepted).
- RAM write and RAM read both occur on the edge entering RESP; data_o loads the read word on that edge and holds until the next completed read.
- stall_o = request present in IDLE, or state = WAIT. Combinational from inputs in IDLE; forced 0 while reset = 1.
- Requester holds all inputs stable while stall_o = 1; changes during WAIT are undefined behaviour (bench assertion).

## Timing
- Request in cycle N (IDLE): stall_o high cycles N..N+WAIT_STATES, RESP in cycle N+WAIT_STATES+1 with done_o = 1 and data_o valid.
- WAIT_STATES = 0: one stall cycle, done in N+1.
- Back-to-back requests: minimum one IDLE cycle between RESP and next acceptance; throughput one access per WAIT_STATES+2 cycles.
- Reset values: state IDLE, counter 0, data_o 0, done_o 0, misaligned_o 0, stall_o 0. RAM contents not cleared.
- Reset in WAIT aborts: no write performed, no done_o.
- Counter width $clog2(WAIT_STATES+1), minimum 1 bit.

## Structure
- Shared package mem_resp_pkg: state enum (IDLE, WAIT, RESP), WORD_ALIGN_BITS = 2, MAX_WAIT_STATES = 15.
- One sub-module: sp_ram (synchronous single-port RAM, DATA_WIDTH × MEMORY_DEPTH, write-enable, registered read-first output), instantiated once; FSM and counter in the top.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles with no request; stall_o stays 0 during reset even with mem_read_i = 1.
- WAIT_STATES = 2, write 0xDEADBEEF to 0x10, then read 0x10: each access stall_o high 3 cycles, done_o on 4th, read returns 0xDEADBEEF.
- WAIT_STATES = 0, alternating writes/reads to 0x0, 0x4, 0x3FC: done 1 cycle after each request; 0x400 aliases to 0x0 and returns its data.
- Misaligned read at 0x12: no RAM access, misaligned_o and done_o pulse together, data_o unchanged.
- Simultaneous mem_read_i/mem_write_i to 0x20 with 0x12345678: write stored, data_o unchanged; subsequent read of 0x20 returns 0x12345678.
- Reset asserted in 2nd WAIT cycle of a write of 0xCAFE0000 to 0x8: FSM IDLE next cycle, no done_o; later read of 0x8 returns prior contents.
